syn_gpu_core_euclid: RTL and testbench

//  Line-draw engine; sits on the euclid modport of the GPU core job interface.

---
 rtl/syn_gpu_pkg.sv | 23 ++
 rtl/syn_gpu_core_euclid_if.sv | 24 ++
 rtl/syn_gpu_euclid_step.sv | 47 ++++
 rtl/syn_gpu_core_euclid.sv | 124 ++++++++++++
 tb/tb_syn_gpu_core_euclid.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/syn_gpu_pkg.sv
// Shared types and constants for the GPU core job interface and the euclid line engine.
package syn_gpu_pkg;

    localparam int unsigned P_GPU_X_W   = 10;
    localparam int unsigned P_GPU_Y_W   = 9;
    localparam int unsigned P_GPU_COL_W = 8;

    typedef struct packed {
        logic [P_GPU_X_W-1:0]   x0;
        logic [P_GPU_Y_W-1:0]   y0;
        logic [P_GPU_X_W-1:0]   x1;
        logic [P_GPU_Y_W-1:0]   y1;
        logic [P_GPU_COL_W-1:0] color;
    } gpu_draw_job_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } euclid_state_e;

endpackage

// File: rtl/syn_gpu_core_euclid_if.sv
// GPU core job interface: job master issues a draw job, the euclid engine reports busy/done.
interface syn_gpu_core_job_intf;
    import syn_gpu_pkg::*;

    logic          euclid_job_start;
    gpu_draw_job_t euclid_job_data;
    logic          euclid_busy;
    logic          euclid_job_done;

    modport master (
        output euclid_job_start,
        output euclid_job_data,
        input  euclid_busy,
        input  euclid_job_done
    );

    modport euclid (
        input  euclid_job_start,
        input  euclid_job_data,
        output euclid_busy,
        output euclid_job_done
    );

endinterface

// File: rtl/syn_gpu_euclid_step.sv
// Combinational Bresenham step: next error term and next pixel from the current one.
module syn_gpu_euclid_step
    import syn_gpu_pkg::*;
#(
    parameter int unsigned P_X_W = P_GPU_X_W,
    parameter int unsigned P_Y_W = P_GPU_Y_W
) (
    input  logic signed [P_X_W+1:0] err,
    input  logic [P_X_W-1:0]        dx,
    input  logic [P_Y_W-1:0]        dy,
    input  logic                    sx_neg,
    input  logic                    sy_neg,
    input  logic [P_X_W-1:0]        cur_x,
    input  logic [P_Y_W-1:0]        cur_y,
    output logic signed [P_X_W+1:0] err_nxt,
    output logic [P_X_W-1:0]        x_nxt,
    output logic [P_Y_W-1:0]        y_nxt
);
    localparam int unsigned E_W = P_X_W + 2;

    // One guard bit so 2*err never wraps regardless of the error excursion.
    logic signed [E_W:0] err_w;
    logic signed [E_W:0] e2;
    logic signed [E_W:0] dx_s;
    logic signed [E_W:0] dy_s;
    logic signed [E_W:0] err_acc;

    always_comb begin
        err_w   = (E_W+1)'(err);
        dx_s    = signed'((E_W+1)'(dx));
        dy_s    = signed'((E_W+1)'(dy));
        e2      = err_w <<< 1;
        err_acc = err_w;
        x_nxt   = cur_x;
        y_nxt   = cur_y;
        if (e2 > -dy_s) begin
            err_acc = err_acc - dy_s;
            x_nxt   = sx_neg ? cur_x - P_X_W'(1) : cur_x + P_X_W'(1);
        end
        if (e2 < dx_s) begin
            err_acc = err_acc + dx_s;
            y_nxt   = sy_neg ? cur_y - P_Y_W'(1) : cur_y + P_Y_W'(1);
        end
        err_nxt = E_W'(err_acc);
    end

endmodule

// File: rtl/syn_gpu_core_euclid.sv
// Line-draw engine: rasterises one draw job with integer Bresenham, one pixel per accepted beat.
module syn_gpu_core_euclid
    import syn_gpu_pkg::*;
#(
    parameter int unsigned P_X_W   = P_GPU_X_W,
    parameter int unsigned P_Y_W   = P_GPU_Y_W,
    parameter int unsigned P_COL_W = P_GPU_COL_W
) (
    input  logic                    clk_ir,
    input  logic                    rst_il,
    syn_gpu_core_job_intf.euclid    job,
    output logic                    pxl_valid_o,
    input  logic                    pxl_ready_i,
    output logic [P_X_W-1:0]        pxl_x_o,
    output logic [P_Y_W-1:0]        pxl_y_o,
    output logic [P_COL_W-1:0]      pxl_color_o
);
    localparam int unsigned E_W = P_X_W + 2;

    euclid_state_e          state;
    gpu_draw_job_t          job_q;
    logic [P_X_W-1:0]       dx_q;
    logic [P_Y_W-1:0]       dy_q;
    logic                   sx_neg_q;
    logic                   sy_neg_q;
    logic signed [E_W-1:0]  err_q;
    logic                   busy_q;
    logic                   done_q;

    logic [P_X_W-1:0]       dx_c;
    logic [P_Y_W-1:0]       dy_c;
    logic signed [E_W-1:0]  err_nxt;
    logic [P_X_W-1:0]       x_nxt;
    logic [P_Y_W-1:0]       y_nxt;
    logic                   at_end;

    // Segment extents from the latched job, used only in SETUP.
    always_comb begin
        dx_c   = (job_q.x1 >= job_q.x0) ? job_q.x1 - job_q.x0 : job_q.x0 - job_q.x1;
        dy_c   = (job_q.y1 >= job_q.y0) ? job_q.y1 - job_q.y0 : job_q.y0 - job_q.y1;
        at_end = (pxl_x_o == job_q.x1) && (pxl_y_o == job_q.y1);
    end

    syn_gpu_euclid_step #(
        .P_X_W (P_X_W),
        .P_Y_W (P_Y_W)
    ) u_step (
        .err     (err_q),
        .dx      (dx_q),
        .dy      (dy_q),
        .sx_neg  (sx_neg_q),
        .sy_neg  (sy_neg_q),
        .cur_x   (pxl_x_o),
        .cur_y   (pxl_y_o),
        .err_nxt (err_nxt),
        .x_nxt   (x_nxt),
        .y_nxt   (y_nxt)
    );

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            state       <= ST_IDLE;
            job_q       <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            sx_neg_q    <= 1'b0;
            sy_neg_q    <= 1'b0;
            err_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pxl_valid_o <= 1'b0;
            pxl_x_o     <= '0;
            pxl_y_o     <= '0;
            pxl_color_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (job.euclid_job_start) begin
                        job_q  <= job.euclid_job_data;
                        busy_q <= 1'b1;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    dx_q        <= dx_c;
                    dy_q        <= dy_c;
                    sx_neg_q    <= job_q.x1 < job_q.x0;
                    sy_neg_q    <= job_q.y1 < job_q.y0;
                    err_q       <= signed'(E_W'(dx_c)) - signed'(E_W'(dy_c));
                    pxl_x_o     <= job_q.x0;
                    pxl_y_o     <= job_q.y0;
                    pxl_color_o <= job_q.color;
                    pxl_valid_o <= 1'b1;
                    state       <= ST_DRAW;
                end
                ST_DRAW: begin
                    // Stall holds every output; the end check precedes any step so the walk never overshoots.
                    if (pxl_ready_i) begin
                        if (at_end) begin
                            pxl_valid_o <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            err_q   <= err_nxt;
                            pxl_x_o <= x_nxt;
                            pxl_y_o <= y_nxt;
                        end
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign job.euclid_busy     = busy_q;
    assign job.euclid_job_done = done_q;

endmodule

// File: tb/tb_syn_gpu_core_euclid.sv
// Randomised self-checking bench for syn_gpu_core_euclid against a queue-based Bresenham model.
module tb_syn_gpu_core_euclid;
    import syn_gpu_pkg::*;

    logic        clk_ir = 1'b0;
    logic        rst_il;
    logic        pxl_valid_o;
    logic        pxl_ready_i;
    logic [9:0]  pxl_x_o;
    logic [8:0]  pxl_y_o;
    logic [7:0]  pxl_color_o;

    int n_tests = 0;
    int n_fail  = 0;

    syn_gpu_core_job_intf job_if ();

    syn_gpu_core_euclid dut (
        .clk_ir      (clk_ir),
        .rst_il      (rst_il),
        .job         (job_if),
        .pxl_valid_o (pxl_valid_o),
        .pxl_ready_i (pxl_ready_i),
        .pxl_x_o     (pxl_x_o),
        .pxl_y_o     (pxl_y_o),
        .pxl_color_o (pxl_color_o)
    );

    always #5 clk_ir = ~clk_ir;

    // Reference rasteriser: plain integer Bresenham, pixels packed as x*512+y.
    function automatic void ref_line(input int x0, input int y0, input int x1, input int y1,
                                     output int q[$]);
        int dx, dy, sx, sy, err, e2, x, y;
        q  = {};
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = (y1 > y0) ? y1 - y0 : y0 - y1;
        sx = (x1 >= x0) ? 1 : -1;
        sy = (y1 >= y0) ? 1 : -1;
        err = dx - dy;
        x = x0;
        y = y0;
        for (int k = 0; k < 4096; k++) begin
            q.push_back(x * 512 + y);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; x += sx; end
            if (e2 < dx)  begin err += dx; y += sy; end
        end
    endfunction

    // Issues one job and records what the DUT does; judgement is left to each test.
    task automatic drive_job(input int x0, input int y0, input int x1, input int y1, input int col,
                             input int ready_pct, input int mid_start_beat,
                             output int beats[$], output int first_valid, output int last_beat_it,
                             output int done_it, output int done_cnt, output int busy_cnt,
                             output int stable_bad, output int col_bad, output bit timed_out);
        bit   held, done_seen, rdy;
        int   hx, hy, extra;
        beats = {};
        first_valid = -1; last_beat_it = -1; done_it = -1;
        done_cnt = 0; busy_cnt = 0; stable_bad = 0; col_bad = 0;
        timed_out = 1'b1; held = 1'b0; done_seen = 1'b0; extra = 0; hx = 0; hy = 0;
        job_if.euclid_job_data  = '{x0: P_GPU_X_W'(x0), y0: P_GPU_Y_W'(y0), x1: P_GPU_X_W'(x1),
                                    y1: P_GPU_Y_W'(y1), color: P_GPU_COL_W'(col)};
        job_if.euclid_job_start = 1'b1;
        @(posedge clk_ir); #1;
        job_if.euclid_job_start = 1'b0;
        for (int it = 0; it < 6000; it++) begin
            if (held && !(pxl_valid_o && int'(pxl_x_o) == hx && int'(pxl_y_o) == hy)) stable_bad++;
            held = 1'b0;
            if (job_if.euclid_busy) busy_cnt++;
            if (job_if.euclid_job_done) begin
                done_cnt++;
                if (!done_seen) done_it = it;
                done_seen = 1'b1;
            end
            rdy = ($urandom_range(99) < 32'(ready_pct));
            pxl_ready_i = rdy;
            if (pxl_valid_o) begin
                if (first_valid < 0) first_valid = it;
                if (rdy) begin
                    beats.push_back(int'(pxl_x_o) * 512 + int'(pxl_y_o));
                    if (int'(pxl_color_o) != col) col_bad++;
                    last_beat_it = it;
                    if (mid_start_beat > 0 && beats.size() == mid_start_beat) begin
                        job_if.euclid_job_data  = '{x0: P_GPU_X_W'($urandom), y0: P_GPU_Y_W'($urandom),
                                                    x1: P_GPU_X_W'($urandom), y1: P_GPU_Y_W'($urandom),
                                                    color: P_GPU_COL_W'($urandom)};
                        job_if.euclid_job_start = 1'b1;
                    end
                end else begin
                    held = 1'b1;
                    hx = int'(pxl_x_o);
                    hy = int'(pxl_y_o);
                end
            end
            @(posedge clk_ir); #1;
            job_if.euclid_job_start = 1'b0;
            if (done_seen) begin
                extra++;
                if (extra == 3) begin timed_out = 1'b0; break; end
            end
        end
        pxl_ready_i = 1'b0;
    endtask

    // Compares a captured run against the model and the protocol timing rules.
    task automatic run_and_check(input string name, input int x0, input int y0, input int x1,
                                 input int y1, input int col, input int ready_pct, input int mid_beat);
        int exp_q[$], got_q[$];
        int fv, lb, di, dc, bc, sb, cb, bad_idx;
        bit to;
        ref_line(x0, y0, x1, y1, exp_q);
        drive_job(x0, y0, x1, y1, col, ready_pct, mid_beat, got_q, fv, lb, di, dc, bc, sb, cb, to);
        n_tests++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL %s timeout: got %0d want 0", name, to); end
        n_tests++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL %s beats: got %0d want %0d", name, got_q.size(), exp_q.size());
        end
        bad_idx = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (bad_idx < 0 && got_q[i] != exp_q[i]) bad_idx = i;
        n_tests++;
        if (bad_idx !== -1) begin
            n_fail++;
            $display("FAIL %s pixel[%0d]: got (%0d,%0d) want (%0d,%0d)", name, bad_idx,
                     got_q[bad_idx] / 512, got_q[bad_idx] % 512, exp_q[bad_idx] / 512, exp_q[bad_idx] % 512);
        end
        n_tests++;
        if (fv !== 1) begin n_fail++; $display("FAIL %s first_valid_latency: got %0d want 1", name, fv); end
        n_tests++;
        if (di !== lb + 1) begin n_fail++; $display("FAIL %s done_cycle: got %0d want %0d", name, di, lb + 1); end
        n_tests++;
        if (dc !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d want 1", name, dc); end
        n_tests++;
        if (bc !== di) begin n_fail++; $display("FAIL %s busy_cycles: got %0d want %0d", name, bc, di); end
        n_tests++;
        if (sb !== 0) begin n_fail++; $display("FAIL %s stall_stability: got %0d want 0", name, sb); end
        n_tests++;
        if (cb !== 0) begin n_fail++; $display("FAIL %s colour: got %0d bad want 0", name, cb); end
    endtask

    task automatic test_reset();
        rst_il = 1'b0;
        pxl_ready_i = 1'b0;
        job_if.euclid_job_start = 1'b0;
        job_if.euclid_job_data  = '0;
        repeat (3) @(posedge clk_ir);
        #1;
        n_tests++;
        if ({pxl_valid_o, job_if.euclid_busy, job_if.euclid_job_done} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000",
                               {pxl_valid_o, job_if.euclid_busy, job_if.euclid_job_done});
        end
        n_tests++;
        if ({pxl_x_o, pxl_y_o, pxl_color_o} !== 27'd0) begin
            n_fail++; $display("FAIL reset_pixel: got %0d,%0d,%0d want 0,0,0", pxl_x_o, pxl_y_o, pxl_color_o);
        end
        rst_il = 1'b1;
        @(posedge clk_ir); #1;
    endtask

    task automatic test_horizontal();
        run_and_check("horizontal", 0, 0, 4, 0, 8'h5a, 100, 0);
    endtask

    task automatic test_steep_negative();
        run_and_check("steep_neg", 3, 5, 1, 0, 8'h11, 100, 0);
    endtask

    task automatic test_degenerate();
        int q[$], fv, lb, di, dc, bc, sb, cb;
        bit to;
        run_and_check("degenerate", 7, 7, 7, 7, 8'hc3, 100, 0);
        drive_job(7, 7, 7, 7, 8'hc3, 100, 0, q, fv, lb, di, dc, bc, sb, cb, to);
        n_tests++;
        if (bc !== 2) begin n_fail++; $display("FAIL degenerate_busy: got %0d want 2", bc); end
        n_tests++;
        if (q.size() !== 1 || q[0] !== 7 * 512 + 7) begin
            n_fail++; $display("FAIL degenerate_pixel: got %0d beats want 1 at (7,7)", q.size());
        end
    endtask

    task automatic test_backpressure();
        run_and_check("backpressure", 0, 0, 8, 3, 8'h3c, 45, 0);
    endtask

    task automatic test_extremes();
        int idle_busy;
        run_and_check("extremes", 1023, 0, 0, 511, 8'hff, 100, 200);
        idle_busy = 0;
        repeat (4) begin
            if (job_if.euclid_busy || pxl_valid_o) idle_busy++;
            @(posedge clk_ir); #1;
        end
        n_tests++;
        if (idle_busy !== 0) begin n_fail++; $display("FAIL extremes_ghost_job: got %0d want 0", idle_busy); end
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            int x0, y0, x1, y1;
            x0 = $urandom_range(1023); x1 = $urandom_range(1023);
            y0 = $urandom_range(511);  y1 = $urandom_range(511);
            if (j < 3) begin x1 = x0 ^ $urandom_range(15); y1 = y0 ^ $urandom_range(31); end
            run_and_check($sformatf("random%0d", j), x0, y0, x1, y1, $urandom_range(255), 70, 0);
        end
    endtask

    task automatic test_reset_mid_draw();
        int beats, seen;
        bit to;
        job_if.euclid_job_data  = '{x0: 10'd0, y0: 9'd0, x1: 10'd20, y1: 9'd5, color: 8'h77};
        job_if.euclid_job_start = 1'b1;
        pxl_ready_i = 1'b1;
        @(posedge clk_ir); #1;
        job_if.euclid_job_start = 1'b0;
        beats = 0; to = 1'b1;
        for (int it = 0; it < 20; it++) begin
            if (pxl_valid_o) beats++;
            @(posedge clk_ir); #1;
            if (beats == 2) begin to = 1'b0; break; end
        end
        n_tests++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL rst_mid_reach_beat2: got timeout want beat 2"); end
        rst_il = 1'b0;
        #1;
        n_tests++;
        if ({pxl_valid_o, job_if.euclid_busy, job_if.euclid_job_done, pxl_x_o, pxl_y_o, pxl_color_o} !== 30'd0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got v%b b%b d%b (%0d,%0d) c%0d want all 0", pxl_valid_o,
                               job_if.euclid_busy, job_if.euclid_job_done, pxl_x_o, pxl_y_o, pxl_color_o);
        end
        @(posedge clk_ir); #1;
        rst_il = 1'b1;
        seen = 0;
        repeat (5) begin
            if (job_if.euclid_job_done || pxl_valid_o || job_if.euclid_busy) seen++;
            @(posedge clk_ir); #1;
        end
        n_tests++;
        if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d active cycles want 0", seen); end
        run_and_check("after_reset", 2, 9, 14, 1, 8'h42, 80, 0);
    endtask

    task automatic test_back_to_back();
        run_and_check("b2b_a", 10, 10, 0, 10, 8'h01, 100, 0);
        run_and_check("b2b_b", 0, 10, 10, 20, 8'h02, 100, 0);
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep_negative();
        test_degenerate();
        test_backpressure();
        test_extremes();
        test_random();
        test_reset_mid_draw();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
